// File: rtl/snn_seq_ctrl.sv
// SNN coprocessor sequencer: preprocess / encode / run / readback-argmax with a CPU stall request.
// Optional per-phase watchdog enabled by defining SNN_WDT_EN.
module snn_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int T_STEPS    = 8,
  parameter int WDT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pre_start_i,
  input  logic                       enc_start_i,
  input  logic [$clog2(NUM_CH)-1:0]  enc_sel_i,
  input  logic                       snn_start_i,
  input  logic                       clear_i,
  input  logic                       wait_snn_i,
  input  logic                       output_snn_i,
  input  logic                       pre_done_i,
  input  logic                       enc_done_i,
  input  logic                       step_done_i,
  input  logic [DATA_WIDTH-1:0]      rd_data_i,
  output logic                       pre_go_o,
  output logic                       enc_go_o,
  output logic [$clog2(NUM_CH)-1:0]  enc_ch_o,
  output logic                       snn_go_o,
  output logic [$clog2(T_STEPS+1)-1:0] step_o,
  output logic                       rd_en_o,
  output logic [$clog2(NUM_CH)-1:0]  rd_idx_o,
  output logic [$clog2(NUM_CH)-1:0]  result_o,
  output logic                       result_valid_o,
  output logic [NUM_CH-1:0]          enc_mask_o,
  output logic                       hold_o,
  output logic                       busy_o,
  output logic [1:0]                 err_o,
  output logic [2:0]                 state_o
);
  localparam int CW = $clog2(NUM_CH);
  localparam int SW = $clog2(T_STEPS+1);
  localparam int RW = $clog2(NUM_CH+2);

  typedef enum logic [2:0] {
    IDLE = 3'd0, PRE = 3'd1, ENC = 3'd2, RUN = 3'd3, DONE = 3'd4, READ = 3'd5
  } state_t;

  state_t                state;
  logic [RW-1:0]         rcnt;
  logic [DATA_WIDTH-1:0] samp, best, best_n;
  logic [CW-1:0]         samp_idx, best_idx, win_idx;
  logic                  samp_vld;
  logic                  wdt_hit;
  logic                  any_cmd;

  assign state_o = state;
  assign any_cmd = pre_start_i | enc_start_i | snn_start_i | output_snn_i;

  // Index 0 always seeds the running max; strict > keeps the lower index on ties.
  always_comb begin
    win_idx = best_idx;
    best_n  = best;
    if (samp_idx == '0 || samp > best) begin
      win_idx = samp_idx;
      best_n  = samp;
    end
  end

`ifdef SNN_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES+1);
  logic [WW-1:0] wdt;
  state_t        prev;
  logic          fresh;

  // First cycle after a state entry or a timestep restart begins a new count.
  assign fresh   = (state != prev) | snn_go_o;
  assign wdt_hit = !fresh && (wdt == WW'(WDT_CYCLES-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdt  <= '0;
      prev <= IDLE;
    end else begin
      prev <= state;
      if (state == PRE || state == ENC || state == RUN)
        wdt <= fresh ? WW'(1) : wdt + WW'(1);
      else
        wdt <= '0;
    end
  end
`else
  assign wdt_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      pre_go_o       <= 1'b0;
      enc_go_o       <= 1'b0;
      snn_go_o       <= 1'b0;
      enc_ch_o       <= '0;
      step_o         <= '0;
      rd_en_o        <= 1'b0;
      rd_idx_o       <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      enc_mask_o     <= '0;
      hold_o         <= 1'b0;
      busy_o         <= 1'b0;
      err_o          <= '0;
      rcnt           <= '0;
      samp           <= '0;
      samp_idx       <= '0;
      samp_vld       <= 1'b0;
      best           <= '0;
      best_idx       <= '0;
    end else begin
      pre_go_o       <= 1'b0;
      enc_go_o       <= 1'b0;
      snn_go_o       <= 1'b0;
      result_valid_o <= 1'b0;
      if (clear_i) begin
        state      <= IDLE;
        busy_o     <= 1'b0;
        hold_o     <= 1'b0;
        step_o     <= '0;
        enc_mask_o <= '0;
        result_o   <= '0;
        err_o      <= '0;
        rd_en_o    <= 1'b0;
        samp_vld   <= 1'b0;
      end else begin
        // hold_o doubles as the wait latch: it can only be set while busy.
        if (wait_snn_i && busy_o) hold_o <= 1'b1;
        if (busy_o && any_cmd)    err_o[0] <= 1'b1;
        unique case (state)
          IDLE, DONE: begin
            if (snn_start_i) begin
              state    <= RUN;
              busy_o   <= 1'b1;
              snn_go_o <= 1'b1;
              step_o   <= '0;
              if (enc_start_i || pre_start_i || output_snn_i) err_o[0] <= 1'b1;
            end else if (state == DONE && output_snn_i) begin
              state    <= READ;
              busy_o   <= 1'b1;
              rd_en_o  <= 1'b1;
              rd_idx_o <= '0;
              rcnt     <= '0;
              if (enc_start_i || pre_start_i) err_o[0] <= 1'b1;
            end else if (state == IDLE && enc_start_i) begin
              state    <= ENC;
              busy_o   <= 1'b1;
              enc_go_o <= 1'b1;
              enc_ch_o <= enc_sel_i;
              if (pre_start_i || output_snn_i) err_o[0] <= 1'b1;
            end else if (state == IDLE && pre_start_i) begin
              state    <= PRE;
              busy_o   <= 1'b1;
              pre_go_o <= 1'b1;
              if (output_snn_i) err_o[0] <= 1'b1;
            end else if (enc_start_i || pre_start_i || output_snn_i) begin
              err_o[0] <= 1'b1;
            end
          end
          PRE: begin
            if (pre_done_i || wdt_hit) begin
              state  <= IDLE;
              busy_o <= 1'b0;
              hold_o <= 1'b0;
              if (!pre_done_i) err_o[1] <= 1'b1;
            end
          end
          ENC: begin
            if (enc_done_i || wdt_hit) begin
              state  <= IDLE;
              busy_o <= 1'b0;
              hold_o <= 1'b0;
              if (enc_done_i) enc_mask_o[enc_ch_o] <= 1'b1;
              else            err_o[1] <= 1'b1;
            end
          end
          RUN: begin
            if (step_done_i) begin
              if (step_o == SW'(T_STEPS-1)) begin
                state  <= DONE;
                busy_o <= 1'b0;
                hold_o <= 1'b0;
                step_o <= SW'(T_STEPS);
              end else begin
                step_o   <= step_o + SW'(1);
                snn_go_o <= 1'b1;
              end
            end else if (wdt_hit) begin
              state    <= IDLE;
              busy_o   <= 1'b0;
              hold_o   <= 1'b0;
              err_o[1] <= 1'b1;
            end
          end
          READ: begin
            // Strobes at rcnt 0..NUM_CH-1, samples captured at 1..NUM_CH, compared one cycle later.
            rcnt    <= rcnt + RW'(1);
            rd_en_o <= (rcnt < RW'(NUM_CH-1));
            if (rcnt < RW'(NUM_CH-1)) rd_idx_o <= CW'(rcnt + RW'(1));
            samp     <= rd_data_i;
            samp_idx <= CW'(rcnt - RW'(1));
            samp_vld <= (rcnt >= RW'(1)) && (rcnt <= RW'(NUM_CH));
            if (samp_vld) begin
              best     <= best_n;
              best_idx <= win_idx;
            end
            if (rcnt == RW'(NUM_CH+1)) begin
              result_o       <= win_idx;
              result_valid_o <= 1'b1;
              state          <= IDLE;
              busy_o         <= 1'b0;
              hold_o         <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
            hold_o <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/snn_seq_ctrl.md
Name: snn_seq_ctrl

Overview:
Parametrised sequencer for the SNN coprocessor, driven by the EX-stage command pulses pre_start, enc_start, snn_start, clear, wait_snn and output_snn.
- Generalises the fixed single-encoder flow to NUM_CH encoder channels and T_STEPS simulation timesteps.
- Stalls the CPU pipeline while a wait_snn is pending.
- Reads back per-class spike counts and produces an argmax classification.
- Sits beside EX and feeds hold into the PC, IF_ID and ID_EX stall path.

Parameters:
DATA_WIDTH, 16, width of spike-count readback data
NUM_CH, 4, number of encoder channels and output classes (>=2)
T_STEPS, 8, SNN timesteps per inference (>=1)
WDT_CYCLES, 1024, watchdog limit in cycles per wait phase (used only with SNN_WDT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
pre_start_i  in  1  command pulse: start preprocessing
enc_start_i  in  1  command pulse: start encoding on channel enc_sel_i
enc_sel_i  in  $clog2(NUM_CH)  encoder channel select, sampled with enc_start_i
snn_start_i  in  1  command pulse: run T_STEPS timesteps
clear_i  in  1  command pulse: abort and clear everything
wait_snn_i  in  1  command pulse: stall CPU until the current operation ends
output_snn_i  in  1  command pulse: read counts and classify
pre_done_i  in  1  preprocessing complete (level or pulse)
enc_done_i  in  1  encoder complete
step_done_i  in  1  one SNN timestep complete
rd_data_i  in  DATA_WIDTH  spike count; valid 1 cycle after rd_en_o
pre_go_o  out  1  one-cycle start pulse to preprocessor
enc_go_o  out  1  one-cycle start pulse to encoder
enc_ch_o  out  $clog2(NUM_CH)  latched encoder channel
snn_go_o  out  1  one-cycle start pulse per timestep
step_o  out  $clog2(T_STEPS+1)  current timestep index
rd_en_o  out  1  count-memory read strobe
rd_idx_o  out  $clog2(NUM_CH)  count-memory read address
result_o  out  $clog2(NUM_CH)  winning class index
result_valid_o  out  1  one-cycle pulse when result_o is updated
enc_mask_o  out  NUM_CH  channels encoded since the last clear
hold_o  out  1  CPU stall request
busy_o  out  1  state is not IDLE or DONE
err_o  out  2  sticky flags: [0] command dropped, [1] watchdog timeout
state_o  out  3  current state encoding, for debug

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0, including step_o, enc_mask_o, result_o and err_o.
  - Reset mid-operation abandons the operation; no done pulse is required afterwards.
- States and encoding: IDLE=0, PRE=1, ENC=2, RUN=3, DONE=4, READ=5.
- All outputs are registered. A command accepted at edge n gives its state change and go pulse at edge n+1.
- IDLE:
  - pre_start_i -> PRE with pre_go_o.
  - enc_start_i -> ENC with enc_go_o; enc_ch_o <= enc_sel_i.
  - snn_start_i -> RUN with snn_go_o; step_o <= 0.
  - Command priority when several are asserted: clear > snn_start > enc_start > pre_start. Each lower command that is dropped sets err_o[0].
  - output_snn_i in IDLE sets err_o[0].
- PRE: on pre_done_i -> IDLE.
- ENC: on enc_done_i -> IDLE; enc_mask_o[enc_ch_o] <= 1.
- RUN: on step_done_i:
  - If step_o == T_STEPS-1 -> DONE, with step_o <= T_STEPS.
  - Otherwise step_o <= step_o+1 and snn_go_o is pulsed in the same edge.
- DONE:
  - output_snn_i -> READ; rd_idx_o <= 0; rd_en_o <= 1.
  - snn_start_i is accepted exactly as in IDLE.
- READ:
  - rd_en_o stays high for NUM_CH consecutive cycles with rd_idx_o = 0..NUM_CH-1.
  - Each rd_data_i is captured the cycle after its strobe.
  - Running max is unsigned; on a tie the lower index wins (strict > compare).
  - After the last sample, result_o is updated, result_valid_o pulses for 1 cycle, and the state goes to IDLE.
  - Total: NUM_CH+2 cycles from entering READ to result_valid_o.
- Commands other than clear received in PRE, ENC, RUN or READ are ignored and set err_o[0].
- clear_i in any state, on the same edge:
  - Goes to IDLE.
  - Clears step_o, enc_mask_o, result_o, err_o and the wait latch.
  - Suppresses any go pulse or result_valid_o that would otherwise have been issued.
- wait_snn_i:
  - Sets a wait latch.
  - hold_o = latch & busy_o, registered.
  - The latch clears when the state reaches IDLE or DONE.
  - wait_snn_i in IDLE or DONE is a no-op, so hold_o never asserts there.
- busy_o = state in {PRE, ENC, RUN, READ}.
- Done inputs received outside their matching state are ignored.
- A done input arriving in the same cycle as the go pulse counts only if the state is already the waiting state.

Optional Feature:
SNN_WDT_EN:
- Defined:
  - A counter resets on every state entry and every snn_go_o.
  - It increments while in PRE, ENC or RUN.
  - On reaching WDT_CYCLES-1 without the awaited done: state -> IDLE, err_o[1] <= 1, wait latch cleared.
- Undefined: no counter logic; err_o[1] is tied to 0; waits are unbounded.

Test Plan:
- Reset then pre_start_i pulse, pre_done_i 5 cycles later -> pre_go_o one cycle at edge+1, busy_o 1 for 5 cycles, state_o returns to 0, err_o=0.
- enc_start_i with enc_sel_i=2, then enc_done_i -> enc_ch_o=2, enc_mask_o=4'b0100; repeat with sel 0 -> enc_mask_o=4'b0101.
- snn_start_i plus wait_snn_i, T_STEPS=8, step_done_i 3 cycles after each snn_go_o -> exactly 8 snn_go_o pulses, hold_o high until DONE, step_o=8, state_o=4.
- From DONE, output_snn_i with rd_data = {3,9,9,1} -> rd_idx 0..3 on consecutive cycles, result_o=1, result_valid_o single pulse 6 cycles after entry into READ, state IDLE.
- In RUN at step 4, assert clear_i together with step_done_i -> next edge state IDLE, step_o=0, no snn_go_o, hold_o=0; pre_start_i issued during RUN before the clear -> err_o[0] was 1, then cleared by clear_i.
- With SNN_WDT_EN and WDT_CYCLES=16: pre_start_i and never pre_done_i -> state IDLE 16 cycles after entry into PRE, err_o=2'b10. Without the macro -> state stays PRE after 100 cycles, err_o=0.
